// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-addressed synchronous-read data memory.
// Splits byte/half/word requests into word reads, read-modify-write stores and lane-extracted loads.
//
//   state | meaning
//   IDLE  | ready; latch request on req_valid
//   READ  | mem_read strobe, memory registers the word
//   CAP   | sample mem_rdata: extend for loads, merge lane for sub-word stores
//   WRITE | mem_write strobe with merged or full word
//   RESP  | one-cycle resp_valid
module lsu_mem_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAP   = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    state_t        state;
    state_t        state_nx;
    logic          accept;
    logic          req_err;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          uns_q;
    logic [31:0]   wword_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_val;
    logic [31:0]   merged;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_addr >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (req_write && req_size == 2'b10)
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
            READ:    state_nx = CAP;
            CAP:     state_nx = write_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_read   = (state == READ);
        mem_write  = (state == WRITE);
        mem_wdata  = (state == WRITE) ? wword_q : 32'h0;
        mem_addr   = {{(32 - AW){1'b0}}, addr_q[AW+1:2]};
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Little-endian lanes selected by the latched low address bits.
    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wword_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wword_q[15:0];
            default: merged = wword_q;
        endcase
    end

    // Response registers are loaded only on the edge that enters RESP and hold otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            wword_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr[AW+1:0];
                size_q  <= req_size;
                write_q <= req_write;
                uns_q   <= req_unsigned;
                wword_q <= req_wdata;
                if (req_err) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
            if (state == CAP) begin
                if (write_q) begin
                    wword_q <= merged;
                end else begin
                    rdata_q <= load_val;
                    err_q   <= 1'b0;
                end
            end
            if (state == WRITE) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a byte-array reference model.
module tb_lsu_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.DEPTH(64), .AW(6)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Attached memory and strobe monitor
    logic [31:0] tb_mem [64] = '{default: 32'h0};
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, bad_cnt = 0;
    logic [31:0] last_rd_addr = 32'h0, last_wr_addr = 32'h0;

    always @(posedge CLK) begin
        if (mem_write) begin
            tb_mem[mem_addr[5:0]] <= mem_wdata;
            wr_cnt++;
            last_wr_addr = mem_addr;
        end
        if (mem_read) begin
            mem_rdata <= tb_mem[mem_addr[5:0]];
            rd_cnt++;
            last_rd_addr = mem_addr;
        end
        if (mem_read && mem_write)
            both_cnt++;
        if ((mem_read || mem_write) && mem_addr[31:6] != 26'h0)
            bad_cnt++;
    end

    // Reference model: byte-addressed memory image
    logic [7:0] ref_mem [256] = '{default: 8'h0};

    function automatic logic m_err(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] sz, logic u, logic [31:0] a);
        int n = 1 << sz;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[int'(a[7:0]) + i]) << (8 * i));
        if (!u && n < 4 && v[8 * n - 1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = 1 << sz;
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = wd >> (8 * i);
            ref_mem[int'(a[7:0]) + i] = t[7:0];
        end
    endtask

    function automatic int m_lat(logic w, logic [1:0] sz, logic [31:0] a);
        if (m_err(sz, a)) return 1;
        if (!w) return 3;
        return (sz == 2'b10) ? 2 : 4;
    endfunction

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int rd_d, output int wr_d);
        int r0, w0;
        rdata = 32'h0; err = 1'b0; lat = 0; rd_d = 0; wr_d = 0;
        @(negedge CLK);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        r0 = rd_cnt; w0 = wr_cnt;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 10; k++) begin
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(negedge CLK);
        end
        if (lat == 0) begin
            check("resp_timeout", 32'(resp_valid), 32'h1);
            return;
        end
        @(negedge CLK);
        check("resp_one_cycle", 32'(resp_valid), 32'h0);
        check("ready_after_resp", 32'(req_ready), 32'h1);
        rd_d = rd_cnt - r0;
        wr_d = wr_cnt - w0;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
        vec_t v;
        v.w = w; v.sz = sz; v.u = u; v.addr = a; v.wd = wd;
        v.exp_rd = er; v.exp_err = ee; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, rdd, wrd, r0, w0, k_resp1, k_resp2, busy_ready, ready5;
        logic [31:0] rd2, exp_v;
        logic        er2;
        logic        w, u;
        logic [1:0]  sz;
        logic [31:0] a, wd;

        // Reset values, checked while RST is held low
        #3;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_read", 32'(mem_read), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        //    w     sz     u     addr    wdata          exp_rdata      err  lat
        addv(1'b1, 2'd2, 1'b0, 32'h04,  32'h11223344, 32'h0,         1'b0, 2);
        addv(1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,         1'b0, 2);
        addv(1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0, 3);
        addv(1'b1, 2'd0, 1'b0, 32'h11,  32'hA5A5A512, 32'h0,         1'b0, 4);
        addv(1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD12EF,  1'b0, 3);
        addv(1'b1, 2'd1, 1'b0, 32'h12,  32'h1234ABCD, 32'h0,         1'b0, 4);
        addv(1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hABCD12EF,  1'b0, 3);
        addv(1'b0, 2'd0, 1'b0, 32'h10,  32'h0,        32'hFFFFFFEF,  1'b0, 3);
        addv(1'b0, 2'd0, 1'b1, 32'h10,  32'h0,        32'h000000EF,  1'b0, 3);
        addv(1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFFABCD,  1'b0, 3);
        addv(1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h0000ABCD,  1'b0, 3);
        addv(1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFFAB,  1'b0, 3);
        addv(1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'h000012EF,  1'b0, 3);
        addv(1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        32'h0,         1'b1, 1);
        addv(1'b1, 2'd1, 1'b0, 32'h13,  32'h5555,     32'h0,         1'b1, 1);
        addv(1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,         1'b1, 1);
        addv(1'b1, 2'd2, 1'b0, 32'h100, 32'h77777777, 32'h0,         1'b1, 1);
        addv(1'b1, 2'd0, 1'b0, 32'hFF,  32'h00000080, 32'h0,         1'b0, 4);
        addv(1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,        32'h80000000,  1'b0, 3);
        addv(1'b0, 2'd0, 1'b0, 32'hFF,  32'h0,        32'hFFFFFF80,  1'b0, 3);
        addv(1'b0, 2'd0, 1'b1, 32'h100, 32'h0,        32'h0,         1'b1, 1);
        addv(1'b1, 2'd3, 1'b0, 32'h14,  32'h12345678, 32'h0,         1'b1, 1);
        addv(1'b0, 2'd0, 1'b1, 32'h05,  32'h0,        32'h00000033,  1'b0, 3);
        addv(1'b0, 2'd1, 1'b0, 32'h06,  32'h0,        32'h00001122,  1'b0, 3);

        foreach (vecs[i]) begin
            run_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wd, rd, er, lat, rdd, wrd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_reads", i), 32'(rdd),
                  (vecs[i].exp_err || (vecs[i].w && vecs[i].sz == 2'd2)) ? 32'h0 : 32'h1);
            check($sformatf("vec%0d_writes", i), 32'(wrd),
                  (!vecs[i].exp_err && vecs[i].w) ? 32'h1 : 32'h0);
            if (!vecs[i].exp_err && vecs[i].w)
                check($sformatf("vec%0d_wr_addr", i), last_wr_addr, vecs[i].addr >> 2);
            if (!vecs[i].exp_err && !(vecs[i].w && vecs[i].sz == 2'd2))
                check($sformatf("vec%0d_rd_addr", i), last_rd_addr, vecs[i].addr >> 2);
            if (!vecs[i].exp_err && vecs[i].w)
                m_store(vecs[i].sz, vecs[i].addr, vecs[i].wd);
        end

        // Reset during CAP of sb @0x5 drops the pending write
        @(negedge CLK);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h5; req_wdata = 32'h77;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
        w0 = wr_cnt;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        check("rmw_read_strobe", 32'(mem_read), 32'h1);
        @(negedge CLK);
        check("rmw_cap_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
        #1 RST = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 32'h1);
        check("midrst_mem_write", 32'(mem_write), 32'h0);
        check("midrst_resp_valid", 32'(resp_valid), 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_mem_wdata", mem_wdata, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("midrst_ready_after", 32'(req_ready), 32'h1);
        check("midrst_no_write", 32'(wr_cnt - w0), 32'h0);
        run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er, lat, rdd, wrd);
        check("midrst_word1", rd, 32'h11223344);

        // Busy ignore: lw @0x20 held valid across an in-flight sb @0x21
        @(negedge CLK);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h21; req_wdata = 32'h5A;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
        r0 = rd_cnt; w0 = wr_cnt;
        @(posedge CLK);
        @(negedge CLK);
        req_write = 1'b0; req_size = 2'd2; req_addr = 32'h20; req_wdata = $urandom;
        m_store(2'd0, 32'h21, 32'h5A);
        exp_v = m_load(2'd2, 1'b0, 32'h20);
        k_resp1 = 0; k_resp2 = 0; busy_ready = 0; ready5 = 0; rd2 = 32'h0; er2 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (resp_valid) begin
                if (k_resp1 == 0) k_resp1 = k;
                else if (k_resp2 == 0) begin
                    k_resp2 = k; rd2 = resp_rdata; er2 = resp_err;
                end
            end
            if (k <= 4 && req_ready) busy_ready++;
            if (k == 5) ready5 = int'(req_ready);
            if (k == 6) req_valid = 1'b0;
            @(negedge CLK);
        end
        check("busy_sb_latency", 32'(k_resp1), 32'd4);
        check("busy_ready_low", 32'(busy_ready), 32'd0);
        check("busy_ready_idle", 32'(ready5), 32'd1);
        check("busy_lw_resp_cycle", 32'(k_resp2), 32'd8);
        check("busy_lw_rdata", rd2, exp_v);
        check("busy_lw_err", 32'(er2), 32'h0);
        check("busy_reads", 32'(rd_cnt - r0), 32'd2);
        check("busy_writes", 32'(wr_cnt - w0), 32'd1);

        // Random traffic against the byte-array model
        for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       a = 32'h100 + $urandom_range(0, 31);
                1:       a = $urandom;
                2, 3, 4: a = $urandom_range(0, 31);
                default: a = $urandom_range(0, 255);
            endcase
            if (sz != 2'd3 && $urandom_range(0, 3) != 0)
                a = a & ~((32'h1 << sz) - 32'h1);
            wd = $urandom;
            exp_v = (w || m_err(sz, a)) ? 32'h0 : m_load(sz, u, a);
            run_req(w, sz, u, a, wd, rd, er, lat, rdd, wrd);
            check($sformatf("rnd%0d_rdata", n), rd, exp_v);
            check($sformatf("rnd%0d_err", n), 32'(er), 32'(m_err(sz, a)));
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(m_lat(w, sz, a)));
            check($sformatf("rnd%0d_reads", n), 32'(rdd),
                  (m_err(sz, a) || (w && sz == 2'd2)) ? 32'h0 : 32'h1);
            check($sformatf("rnd%0d_writes", n), 32'(wrd), (!m_err(sz, a) && w) ? 32'h1 : 32'h0);
            if (!m_err(sz, a) && w)
                m_store(sz, a, wd);
        end

        check("strobes_never_both", 32'(both_cnt), 32'h0);
        check("mem_addr_upper_zero", 32'(bad_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller that sits directly upstream of the word-addressed data memory (64 x 32-bit, synchronous read, MemRead/MemWrite mutually exclusive).
- Accepts byte-addressed load/store requests of byte, halfword or word size from the CPU datapath.
- Converts each request into word-level memory accesses:
  - read-modify-write for sub-word stores;
  - lane extraction plus sign/zero extension for loads.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached memory; valid byte addresses are 0 .. 4*DEPTH-1.
- AW, 6, word-index width, equal to clog2(DEPTH).

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned, out of range, or illegal size.
- mem_addr  out  32  word index, zero-extended addr[AW+1:2].
- mem_wdata  out  32  word written to memory.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe; the memory registers data at this edge.
- mem_rdata  in  32  memory read data, valid the cycle after a mem_read cycle.

Behaviour:
- Reset (RST=0, asynchronous):
  - state = IDLE.
  - req_ready = 1.
  - resp_valid, resp_err, mem_read, mem_write = 0.
  - resp_rdata, mem_wdata, mem_addr = 0.
  - All internal latches cleared.
- Reset asserted mid-operation aborts the access. No further memory strobes are issued. A pending RMW write is dropped.
- Accept happens on an edge with req_valid & req_ready. At that edge addr, size, write, unsigned and wdata are latched; inputs are don't-care afterwards.
- Error check at accept, using the latched values:
  - size=11 is an error;
  - half with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error;
  - addr >= 4*DEPTH is an error.
  - On error: next state is RESP with resp_err=1. No mem_read or mem_write is ever asserted.
- State machine: IDLE, READ, CAP, WRITE, RESP.
  - Load: IDLE -> READ -> CAP -> RESP.
  - Word store: IDLE -> WRITE -> RESP.
  - Sub-word store: IDLE -> READ -> CAP -> WRITE -> RESP.
  - RESP -> IDLE unconditionally.
- Strobes:
  - mem_read = 1 only in READ.
  - mem_write = 1 only in WRITE.
  - They are never high together. Both are 0 in IDLE, CAP and RESP.
- mem_addr holds the latched word index from READ through WRITE.
- CAP samples mem_rdata. Lanes are little-endian:
  - byte k (k = addr[1:0]) occupies bits [8k+7:8k];
  - half h (h = addr[1]) occupies bits [16h+15:16h].
- Load result: the selected lane, extended to 32 bits per req_unsigned. Word loads are unmodified. The result is registered into resp_rdata on entry to RESP.
- Sub-word store merge: replace only the selected lane of the sampled word with wdata[7:0] or wdata[15:0]. Other lanes keep their memory value. The merged word is registered and driven on mem_wdata during WRITE.
- Word store: mem_wdata = latched wdata during WRITE.
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - error: 1 cycle;
  - word store: 2 cycles;
  - load: 3 cycles;
  - sub-word store: 4 cycles.
- resp_valid is high exactly one cycle, in RESP. There is no backpressure on the response.
- resp_rdata and resp_err hold their value until the next RESP.
- req_ready drops the cycle after accept and returns in the cycle after RESP. Back-to-back requests therefore leave one idle-accept cycle between them.
- A request presented while busy is ignored and not latched. The requester must hold req_valid until req_ready.

Test Plan:
- Reset mid-RMW: during CAP of sb to addr 0x5, pulse RST low -> state IDLE, no mem_write pulse, word 1 unchanged, req_ready=1 after release.
- Word store then load: sw 0xDEADBEEF @0x10 -> exactly one mem_write with mem_addr=4, resp_valid 2 cycles after accept; then lw @0x10 -> resp_rdata=0xDEADBEEF, 3-cycle latency, resp_err=0.
- Sub-word store RMW: word 4 = 0xDEADBEEF, sb 0x12 @0x11 -> mem_read, then mem_write with mem_wdata=0xDEAD12EF; sh 0xABCD @0x12 -> 0xABCD12EF; latency 4.
- Load extension: word 4 = 0xABCD12EF; lb @0x10 -> 0xFFFFFFEF; lbu @0x10 -> 0x000000EF; lh @0x12 -> 0xFFFFABCD; lhu @0x12 -> 0x0000ABCD.
- Errors: lw @0x12, sh @0x13, size=11, sw @0x100 (DEPTH=64) -> resp_err=1 one cycle after accept, resp_rdata=0, mem_read and mem_write never asserted.
- Busy ignore: hold req_valid with a new lw @0x20 throughout an in-flight sb -> second request accepted only on the edge after RESP. Exactly one mem_read for each request, never both strobes high.
